// File: rtl/rv32i_cpu_single.sv
// Single-cycle RV32I core: PC, register file, ALU, branch unit, instruction
// ROM and a byte-addressed little-endian data RAM. Every instruction fetches,
// decodes, executes and writes back in one clock.

// Byte-addressed data RAM: combinational 4-byte read window, byte-enabled write.
module rv32i_cpu_single_dmem #(
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic [3:0]  wbe,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;

    logic [7:0]    dmem [0:DMEM_BYTES-1];
    logic [AW-1:0] bidx [0:3];
    logic [31:0]   base_s;

    // RAM content is not reset; it starts out all zero.
    initial begin
        for (int i = 0; i < DMEM_BYTES; i++) begin
            dmem[AW'(i)] = 8'h00;
        end
    end

    // Byte indices A..A+3, each wrapped modulo the RAM size.
    always_comb begin
        base_s = addr % 32'(DMEM_BYTES);
        for (int i = 0; i < 4; i++) begin
            bidx[i] = AW'((base_s + 32'(i)) % 32'(DMEM_BYTES));
        end
    end

    // Little-endian read of the four consecutive bytes.
    always_comb begin
        rdata = {dmem[bidx[3]], dmem[bidx[2]], dmem[bidx[1]], dmem[bidx[0]]};
    end

    // Byte-enabled store; bytes without an enable are preserved.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wbe[i]) begin
                dmem[bidx[i]] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

module rv32i_cpu_single #(
    parameter int    IMEM_WORDS = 256,
    parameter int    DMEM_BYTES = 1024,
    parameter string IMEM_FILE  = "program.hex"
) (
    input logic clk,
    input logic reset
);
    localparam int          IW  = $clog2(IMEM_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] rom  [0:IMEM_WORDS-1];
    logic [31:0] regs [0:31];
    logic [31:0] pc, pc_plus4, next_pc, instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, rd_data, mem_addr, mem_rdata, load_val;
    logic [3:0]  mem_wbe, store_wbe;
    logic        rd_we, br_taken, load_ok;

    // Instruction ROM starts out filled with NOP; contents are supplied by the environment.
    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) begin
            rom[i] = NOP;
        end
    end

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        r;
        logic signed [31:0] sra;
        sra = $signed(a) >>> b[4:0];
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, ($signed(a) < $signed(b))};
            3'b011:  r = {31'd0, (a < b)};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? sra : (a >> b[4:0]);
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {instr[31:12], 12'h000};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;
    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    // No store may land while the core is held in reset.
    assign mem_wbe  = reset ? 4'b0000 : store_wbe;

    // Fetch; words beyond the ROM read as NOP.
    always_comb begin
        instr = NOP;
        if (pc[31:2] < 30'(IMEM_WORDS)) begin
            instr = rom[pc[IW+1:2]];
        end else begin
            instr = NOP;
        end
    end

    // Branch condition evaluation; reserved funct3 values never branch.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  br_taken = !($signed(rs1_val) < $signed(rs2_val));
            3'b110:  br_taken = (rs1_val < rs2_val);
            3'b111:  br_taken = !(rs1_val < rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Load data extraction and extension; reserved widths write nothing.
    always_comb begin
        load_val = 32'd0;
        load_ok  = 1'b1;
        case (funct3)
            3'b000:  load_val = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  load_val = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b010:  load_val = mem_rdata;
            3'b100:  load_val = {24'd0, mem_rdata[7:0]};
            3'b101:  load_val = {16'd0, mem_rdata[15:0]};
            default: load_ok  = 1'b0;
        endcase
    end

    // Main decode: next PC, register write-back and store enables.
    always_comb begin
        next_pc   = pc_plus4;
        rd_we     = 1'b0;
        rd_data   = 32'd0;
        store_wbe = 4'b0000;
        mem_addr  = rs1_val + imm_i;
        case (opcode)
            7'b0110111: begin rd_we = 1'b1; rd_data = imm_u; end
            7'b0010111: begin rd_we = 1'b1; rd_data = pc + imm_u; end
            7'b1101111: begin rd_we = 1'b1; rd_data = pc_plus4; next_pc = pc + imm_j; end
            7'b1100111: begin
                if (funct3 == 3'b000) begin
                    rd_we   = 1'b1;
                    rd_data = pc_plus4;
                    next_pc = (rs1_val + imm_i) & ~32'd1;
                end else begin
                    rd_we = 1'b0;
                end
            end
            7'b1100011: begin
                if (br_taken) begin
                    next_pc = pc + imm_b;
                end else begin
                    next_pc = pc_plus4;
                end
            end
            7'b0000011: begin rd_we = load_ok; rd_data = load_val; end
            7'b0100011: begin
                mem_addr = rs1_val + imm_s;
                case (funct3)
                    3'b000:  store_wbe = 4'b0001;
                    3'b001:  store_wbe = 4'b0011;
                    3'b010:  store_wbe = 4'b1111;
                    default: store_wbe = 4'b0000;
                endcase
            end
            7'b0010011: begin
                rd_we   = 1'b1;
                rd_data = alu(funct3, (funct3 == 3'b101) & instr[30], rs1_val, imm_i);
            end
            7'b0110011: begin
                rd_we   = 1'b1;
                rd_data = alu(funct3, instr[30], rs1_val, rs2_val);
            end
            default: next_pc = pc_plus4;
        endcase
    end

    // Program counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= 32'd0;
        end else begin
            pc <= next_pc;
        end
    end

    // Register file write port; x0 is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[5'(i)] <= 32'd0;
            end
        end else if (rd_we && (rd != 5'd0)) begin
            regs[rd] <= rd_data;
        end
    end

    rv32i_cpu_single_dmem #(.DMEM_BYTES(DMEM_BYTES)) dmem (
        .clk   (clk),
        .addr  (mem_addr),
        .wbe   (mem_wbe),
        .wdata (rs2_val),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_rv32i_cpu_single.sv
// Directed-program bench for rv32i_cpu_single: loads small hand-encoded
// programs into the ROM, runs them and compares data RAM words.
module tb_rv32i_cpu_single;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] prog_q[$];

    always #5 clk = ~clk;

    rv32i_cpu_single #(.IMEM_WORDS(256), .DMEM_BYTES(1024), .IMEM_FILE("")) u_dut (
        .clk   (clk),
        .reset (reset)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdw(input logic [9:0] a);
        return {u_dut.dmem.dmem[a + 10'd3], u_dut.dmem.dmem[a + 10'd2],
                u_dut.dmem.dmem[a + 10'd1], u_dut.dmem.dmem[a]};
    endfunction

    // Hold reset, load prog_q (rest NOP), release and run a number of clocks.
    task automatic run_prog(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            u_dut.rom[8'(i)] = (i < prog_q.size()) ? prog_q[i] : 32'h0000_0013;
        end
        #20;
        reset = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #12;
        check("reset_pc", u_dut.pc, 32'd0);
        check("reset_x5", u_dut.regs[5], 32'd0);

        // addi/add/sw
        prog_q = '{32'h00500093, 32'h00700113, 32'h002081B3, 32'h00302023};
        run_prog(20);
        check("add_w0", rdw(10'd0), 32'd12);

        // sign/zero extending byte loads
        prog_q = '{32'hFFF00093, 32'h00100223, 32'h00400103, 32'h00404183,
                   32'h00202423, 32'h00302623};
        run_prog(20);
        check("lb_w8", rdw(10'd8), 32'hFFFF_FFFF);
        check("lbu_w12", rdw(10'd12), 32'h0000_00FF);
        check("sb_w4", rdw(10'd4), 32'h0000_00FF);

        // counted loop with bne
        prog_q = '{32'h00500093, 32'h00310113, 32'hFFF08093, 32'hFE009CE3, 32'h00202023};
        run_prog(20);
        check("loop_w0", rdw(10'd0), 32'd15);

        // jal link value and skipped instruction
        prog_q = '{32'h008000EF, 32'h06300293, 32'h00102023, 32'h00502223};
        run_prog(20);
        check("jal_w0", rdw(10'd0), 32'd4);
        check("jal_skip_w4", rdw(10'd4), 32'd0);

        // x0 immutability, lui, srai, sltu
        prog_q = '{32'h00700013, 32'h800000B7, 32'h4040D113, 32'h001031B3,
                   32'h00002023, 32'h00202223, 32'h00302423};
        run_prog(20);
        check("x0_w0", rdw(10'd0), 32'd0);
        check("srai_w4", rdw(10'd4), 32'hF800_0000);
        check("sltu_w8", rdw(10'd8), 32'd1);

        // sub/slt/sll/srl and a taken blt
        prog_q = '{32'hFFA00093, 32'h00300113, 32'h402081B3, 32'h0020A233,
                   32'h002112B3, 32'h0020D333, 32'h0020C463, 32'h00000193,
                   32'h02302023, 32'h02402223, 32'h02502423, 32'h02602623};
        run_prog(20);
        check("sub_w32", rdw(10'd32), 32'hFFFF_FFF7);
        check("slt_w36", rdw(10'd36), 32'd1);
        check("sll_w40", rdw(10'd40), 32'd24);
        check("srl_w44", rdw(10'd44), 32'h1FFF_FFFF);

        // reset in the middle of an endless loop
        prog_q = '{32'h00102A23, 32'h00108093, 32'h00102823, 32'hFF5FF06F};
        run_prog(10);
        check("pre_w16", rdw(10'd16), 32'd2);
        check("pre_w20", rdw(10'd20), 32'd2);
        reset = 1'b1;
        #1;
        check("mid_pc", u_dut.pc, 32'd0);
        check("mid_x1", u_dut.regs[1], 32'd0);
        #9;
        check("kept_w20", rdw(10'd20), 32'd2);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("restart_w20", rdw(10'd20), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("restart_w16", rdw(10'd16), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
